kernel_kcore_hls_deadlock_report_unit: RTL and testbench
========================================================

Name: kernel_kcore_hls_deadlock_report_unit

Overview:
- Central collector downstream of the per-process deadlock detect units.
- Gathers each unit's local detect output and confirms a stable detection, then selects one origin process and broadcasts the global detect flag.
- Pulses origin, tracks the token as it circulates the dependence loop, and terminates the walk with token_clear.
- Presents a single report (origin, loop members, hop count, timeout flag) on a valid/ready interface to the kernel monitor.

Parameters:
- PROC_NUM, 4, number of HLS processes; one detect unit per process.
- CONFIRM_CYCLES, 8, consecutive cycles a local detect must hold before it is confirmed; must be ≥1.
- TRACE_TIMEOUT, 1024, maximum TRACE cycles before the walk is abandoned.
- HOP_W, 8, width of the hop counter.

Ports:
- reset  in  1  asynchronous, active-low.
- clock  in  1  rising-edge clock.
- proc_dl_detect_vec  in  PROC_NUM  dl_detect_out of each unit, bit i = process i.
- proc_token_vec  in  PROC_NUM  bit i = OR of token_in_vec of unit i; the token is present at process i.
- dl_detect_out  out  1  global detect flag, fanned to dl_detect_in of every unit.
- origin_vec  out  PROC_NUM  one-hot 1-cycle pulse to the origin input of the selected unit.
- token_clear  out  1  1-cycle pulse, broadcast to every unit.
- report_valid  out  1  report handshake valid.
- report_ready  in  1  report handshake ready.
- report_origin  out  PROC_NUM  one-hot origin process.
- report_mask  out  PROC_NUM  processes the token visited.
- report_hops  out  HOP_W  number of token-arrival cycles.
- report_timeout  out  1  walk ended by timeout.
- clear_req  in  1  host acknowledge; re-arms the block.

Behaviour:
- Reset state: all outputs 0; state IDLE; counters and registers 0. A reset mid-operation aborts any walk immediately.
- IDLE:
  - If proc_dl_detect_vec != 0, latch the lowest set index as org (one-hot), set cnt=1, go CONFIRM.
  - If CONFIRM_CYCLES==1, go directly to the LAUNCH action instead.
- CONFIRM:
  - While proc_dl_detect_vec[org]==1, increment cnt.
  - When cnt reaches CONFIRM_CYCLES, go LAUNCH.
  - If proc_dl_detect_vec[org] drops, return to IDLE with cnt=0 and no outputs asserted. Other bits are ignored during CONFIRM.
- LAUNCH (1 cycle):
  - dl_detect_out registers to 1; it stays 1 until the HOLD exit.
  - origin_vec=org for exactly this cycle.
  - Clear mask, hops and timer; go TRACE.
- TRACE:
  - timer increments every cycle.
  - In each cycle with proc_token_vec != 0: mask |= proc_token_vec and hops++ (saturating at all-ones).
  - If proc_token_vec & org != 0, in the cycle after its first arrival from TRACE entry +1 cycle onward:
    - token_clear=1 for 1 cycle, aligned so the units see it in the cycle they assert the next local detect;
    - mask includes org; timeout=0; go REPORT.
  - If timer reaches TRACE_TIMEOUT first: token_clear=1 for 1 cycle, timeout=1, go REPORT.
  - If the origin arrival and the timeout occur in the same cycle, the arrival wins (timeout=0).
- REPORT:
  - report_valid=1; report_* fields are stable while valid.
  - The transfer completes in a cycle with report_valid & report_ready; then go HOLD with valid deasserted next cycle.
- HOLD:
  - dl_detect_out remains 1.
  - On clear_req=1: next cycle dl_detect_out=0, all registers clear, go IDLE.
  - clear_req in any other state is ignored.
- Exactly one report is issued per confirmation. Local detects during LAUNCH, TRACE, REPORT and HOLD are ignored.
- origin_vec and token_clear are never asserted outside the cycles stated above.

Test Plan:
- PROC_NUM=4, CONFIRM_CYCLES=3: proc_dl_detect_vec=4'b0100 held 3 cycles -> after the 3rd held cycle, origin_vec=4'b0100 pulses 1 cycle and dl_detect_out=1 from that cycle.
- proc_dl_detect_vec=4'b0110 simultaneously -> org=4'b0010 (lowest index wins).
- Detect bit held 2 cycles, then dropped (CONFIRM_CYCLES=3) -> no origin pulse, dl_detect_out stays 0, block returns to IDLE.
- After LAUNCH with org=process 1, token arrives at 2, then 3, then 1 on successive cycles -> token_clear pulses 1 cycle after process 1 sees the token; report_origin=4'b0010, report_mask=4'b1110, report_hops=3, report_timeout=0.
- Token never returns to origin, TRACE_TIMEOUT=16 -> token_clear pulses after 16 TRACE cycles; report_timeout=1.
- report_ready held 0 for 5 cycles -> report fields stable and report_valid=1 throughout; after acceptance, clear_req=1 -> dl_detect_out=0 next cycle; a new detect is accepted afterwards. Asserting reset during TRACE -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/kernel_kcore_hls_deadlock_report_unit.sv
// Deadlock report collector: confirms a stable local detect, launches the token walk from one
// origin, records the loop it traces and hands a single report to the kernel monitor.
module kernel_kcore_hls_deadlock_report_unit #(
    parameter int unsigned PROC_NUM       = 4,
    parameter int unsigned CONFIRM_CYCLES = 8,
    parameter int unsigned TRACE_TIMEOUT  = 1024,
    parameter int unsigned HOP_W          = 8
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [PROC_NUM-1:0] proc_dl_detect_vec,
    input  logic [PROC_NUM-1:0] proc_token_vec,
    output logic                dl_detect_out,
    output logic [PROC_NUM-1:0] origin_vec,
    output logic                token_clear,
    output logic                report_valid,
    input  logic                report_ready,
    output logic [PROC_NUM-1:0] report_origin,
    output logic [PROC_NUM-1:0] report_mask,
    output logic [HOP_W-1:0]    report_hops,
    output logic                report_timeout,
    input  logic                clear_req
);

    localparam int unsigned CntW = $clog2(CONFIRM_CYCLES + 1);
    localparam int unsigned TimW = $clog2(TRACE_TIMEOUT + 1);

    typedef enum logic [2:0] {StIdle, StConfirm, StLaunch, StTrace, StReport, StHold} state_e;

    state_e              state_q, state_d;
    logic [PROC_NUM-1:0] org_q, org_d;
    logic [PROC_NUM-1:0] mask_q, mask_d;
    logic [HOP_W-1:0]    hops_q, hops_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [TimW-1:0]     timer_q, timer_d;
    logic                timeout_q, timeout_d;
    logic                clr_q, clr_d;
    logic [PROC_NUM-1:0] lowest;

    // Downward scan so the lowest set index is the last one written.
    always_comb begin
        lowest = '0;
        for (int i = int'(PROC_NUM) - 1; i >= 0; i--) begin
            if (proc_dl_detect_vec[i]) begin
                lowest    = '0;
                lowest[i] = 1'b1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        org_d     = org_q;
        mask_d    = mask_q;
        hops_d    = hops_q;
        cnt_d     = cnt_q;
        timer_d   = timer_q;
        timeout_d = timeout_q;
        clr_d     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (|proc_dl_detect_vec) begin
                    org_d = lowest;
                    if (CONFIRM_CYCLES <= 1) begin
                        state_d = StLaunch;
                    end else begin
                        cnt_d   = CntW'(1);
                        state_d = StConfirm;
                    end
                end
            end
            StConfirm: begin
                if (|(proc_dl_detect_vec & org_q)) begin
                    if (cnt_q + CntW'(1) == CntW'(CONFIRM_CYCLES)) begin
                        cnt_d   = '0;
                        state_d = StLaunch;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end else begin
                    cnt_d   = '0;
                    org_d   = '0;
                    state_d = StIdle;
                end
            end
            StLaunch: begin
                mask_d    = '0;
                hops_d    = '0;
                timer_d   = '0;
                timeout_d = 1'b0;
                state_d   = StTrace;
            end
            StTrace: begin
                timer_d = timer_q + TimW'(1);
                if (|proc_token_vec) begin
                    mask_d = mask_q | proc_token_vec;
                    if (hops_q != {HOP_W{1'b1}}) begin
                        hops_d = hops_q + HOP_W'(1);
                    end
                end
                // A return to the origin beats a timeout expiring in the same cycle.
                if (timer_q != '0 && |(proc_token_vec & org_q)) begin
                    mask_d    = mask_d | org_q;
                    clr_d     = 1'b1;
                    timeout_d = 1'b0;
                    state_d   = StReport;
                end else if (timer_d == TimW'(TRACE_TIMEOUT)) begin
                    clr_d     = 1'b1;
                    timeout_d = 1'b1;
                    state_d   = StReport;
                end
            end
            StReport: begin
                if (report_ready) begin
                    state_d = StHold;
                end
            end
            StHold: begin
                if (clear_req) begin
                    org_d     = '0;
                    mask_d    = '0;
                    hops_d    = '0;
                    cnt_d     = '0;
                    timer_d   = '0;
                    timeout_d = 1'b0;
                    state_d   = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            org_q     <= '0;
            mask_q    <= '0;
            hops_q    <= '0;
            cnt_q     <= '0;
            timer_q   <= '0;
            timeout_q <= 1'b0;
            clr_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            org_q     <= org_d;
            mask_q    <= mask_d;
            hops_q    <= hops_d;
            cnt_q     <= cnt_d;
            timer_q   <= timer_d;
            timeout_q <= timeout_d;
            clr_q     <= clr_d;
        end
    end

    assign dl_detect_out  = (state_q == StLaunch) || (state_q == StTrace) ||
                            (state_q == StReport) || (state_q == StHold);
    assign origin_vec     = (state_q == StLaunch) ? org_q : '0;
    assign token_clear    = clr_q;
    assign report_valid   = (state_q == StReport);
    assign report_origin  = report_valid ? org_q : '0;
    assign report_mask    = report_valid ? mask_q : '0;
    assign report_hops    = report_valid ? hops_q : '0;
    assign report_timeout = report_valid & timeout_q;

endmodule

// File: tb/tb_kernel_kcore_hls_deadlock_report_unit.sv
// Scoreboard bench for the deadlock report collector: stimulus pushes expected origin pulses,
// token_clear pulses and reports with their cycle numbers; a monitor pops them as they appear.
module tb_kernel_kcore_hls_deadlock_report_unit;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] proc_dl_detect_vec = '0;
    logic [3:0] proc_token_vec = '0;
    logic       dl_detect_out;
    logic [3:0] origin_vec;
    logic       token_clear;
    logic       report_valid;
    logic       report_ready = 1'b1;
    logic [3:0] report_origin;
    logic [3:0] report_mask;
    logic [7:0] report_hops;
    logic       report_timeout;
    logic       clear_req = 1'b0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        int         kind;  // 0 origin pulse, 1 token_clear, 2 report transfer
        int         cyc;
        logic [3:0] vec;
        logic [3:0] mask;
        int         hops;
        logic       to;
    } evt_t;
    evt_t q[$];

    kernel_kcore_hls_deadlock_report_unit #(
        .PROC_NUM(4), .CONFIRM_CYCLES(3), .TRACE_TIMEOUT(16), .HOP_W(8)
    ) dut (
        .clock(clock), .reset(reset),
        .proc_dl_detect_vec(proc_dl_detect_vec), .proc_token_vec(proc_token_vec),
        .dl_detect_out(dl_detect_out), .origin_vec(origin_vec), .token_clear(token_clear),
        .report_valid(report_valid), .report_ready(report_ready),
        .report_origin(report_origin), .report_mask(report_mask),
        .report_hops(report_hops), .report_timeout(report_timeout),
        .clear_req(clear_req)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int kind, input int c, input logic [3:0] vec,
                        input logic [3:0] mask, input int hops, input logic to);
        evt_t e;
        e.kind = kind; e.cyc = c; e.vec = vec; e.mask = mask; e.hops = hops; e.to = to;
        q.push_back(e);
    endtask

    task automatic check_evt(input int kind);
        evt_t e;
        logic ok;
        checks++;
        if (q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: got kind %0d at cycle %0d, want none", kind, cyc);
        end else begin
            e = q.pop_front();
            ok = (e.kind == kind) && (e.cyc == cyc);
            if (kind == 0) ok = ok && (origin_vec == e.vec) && dl_detect_out;
            if (kind == 2) ok = ok && (report_origin == e.vec) && (report_mask == e.mask) &&
                                (int'(report_hops) == e.hops) && (report_timeout == e.to);
            if (!ok) begin
                errors++;
                $display("FAIL event_%0d: got kind=%0d cyc=%0d vec=%b org=%b mask=%b hops=%0d to=%b dl=%b, want kind=%0d cyc=%0d vec=%b mask=%b hops=%0d to=%b",
                         kind, kind, cyc, origin_vec, report_origin, report_mask, report_hops,
                         report_timeout, dl_detect_out, e.kind, e.cyc, e.vec, e.mask, e.hops, e.to);
            end
        end
    endtask

    logic        stalled = 1'b0;
    logic [16:0] held_fields;

    always @(negedge clock) begin
        if (origin_vec != '0) check_evt(0);
        if (token_clear) check_evt(1);
        if (report_valid && report_ready) check_evt(2);
        if (report_valid && stalled)
            chk("stall_stable", 32'({report_origin, report_mask, report_hops, report_timeout}),
                32'(held_fields));
        stalled     = report_valid && !report_ready;
        held_fields = {report_origin, report_mask, report_hops, report_timeout};
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_to(input int target);
        while (cyc < target) step();
    endtask

    task automatic walk(input logic [15:0] seq, input int n);
        step();
        for (int i = 0; i < n; i++) begin
            step();
            proc_token_vec = seq[4*i +: 4];
        end
        step();
        proc_token_vec = '0;
    endtask

    task automatic hold_clear(input string name);
        step();
        chk({name, "_hold_dl"}, 32'(dl_detect_out), 32'd1);
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        chk({name, "_clear_dl"}, 32'(dl_detect_out), 32'd0);
    endtask

    // Confirm, walk a token sequence ending at the origin, then accept and clear the report.
    task automatic run_ok(input string name, input logic [3:0] det, input logic [3:0] org,
                          input logic [15:0] seq, input int n, input logic [3:0] mask,
                          input int hops, input int stall);
        int l;
        int r;
        proc_dl_detect_vec = det;
        l = cyc + 3;
        r = l + 2 + n;
        push(0, l, org, '0, 0, 1'b0);
        push(1, r, '0, '0, 0, 1'b0);
        push(2, r + stall, org, mask, hops, 1'b0);
        report_ready = (stall == 0);
        repeat (3) step();
        proc_dl_detect_vec = '0;
        chk({name, "_launch_dl"}, 32'(dl_detect_out), 32'd1);
        walk(seq, n);
        for (int i = 0; i < stall; i++) begin
            chk({name, "_stall_valid"}, 32'(report_valid), 32'd1);
            step();
        end
        report_ready = 1'b1;
        hold_clear(name);
    endtask

    initial begin
        int l;
        repeat (2) step();
        chk("reset_outputs", 32'({dl_detect_out, origin_vec, token_clear, report_valid,
            report_origin, report_mask, report_hops, report_timeout}), 32'd0);
        reset = 1'b1;
        step();

        run_ok("single", 4'b0100, 4'b0100, 16'h0004, 1, 4'b0100, 1, 0);
        run_ok("loop", 4'b0110, 4'b0010, 16'h0284, 3, 4'b1110, 3, 5);

        // Detect dropped after two held cycles: no launch.
        proc_dl_detect_vec = 4'b0001;
        repeat (2) step();
        proc_dl_detect_vec = '0;
        step();
        chk("abort_dl", 32'(dl_detect_out), 32'd0);
        repeat (3) step();
        chk("abort_dl_later", 32'(dl_detect_out), 32'd0);

        // Token never returns; detect held high throughout to show it is ignored.
        proc_dl_detect_vec = 4'b1000;
        l = cyc + 3;
        push(0, l, 4'b1000, '0, 0, 1'b0);
        push(1, l + 17, '0, '0, 0, 1'b0);
        push(2, l + 17, 4'b1000, 4'b0011, 2, 1'b1);
        repeat (3) step();
        walk(16'h0021, 2);
        wait_to(l + 17);
        proc_dl_detect_vec = '0;
        hold_clear("timeout");

        // Origin arrival in the same cycle the timer expires.
        proc_dl_detect_vec = 4'b0001;
        l = cyc + 3;
        push(0, l, 4'b0001, '0, 0, 1'b0);
        push(1, l + 17, '0, '0, 0, 1'b0);
        push(2, l + 17, 4'b0001, 4'b0001, 1, 1'b0);
        repeat (3) step();
        proc_dl_detect_vec = '0;
        wait_to(l + 16);
        proc_token_vec = 4'b0001;
        step();
        proc_token_vec = '0;
        hold_clear("tie");

        // Asynchronous reset in the middle of a walk.
        proc_dl_detect_vec = 4'b0010;
        l = cyc + 3;
        push(0, l, 4'b0010, '0, 0, 1'b0);
        repeat (3) step();
        proc_dl_detect_vec = '0;
        repeat (2) step();
        chk("trace_dl", 32'(dl_detect_out), 32'd1);
        #2 reset = 1'b0;
        #1 chk("async_reset", 32'({dl_detect_out, origin_vec, token_clear, report_valid,
            report_origin, report_mask, report_hops, report_timeout}), 32'd0);
        step();
        reset = 1'b1;
        step();

        run_ok("after_reset", 4'b0100, 4'b0100, 16'h0004, 1, 4'b0100, 1, 0);

        repeat (3) step();
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
